// File: rtl/floor_request_ctrl.sv
// Four-floor elevator call scheduler: latches calls, SCAN direction choice, travel/dwell timing, floor tracking.
// Latency: a call is latched on the first edge; the move decision comes one edge later; a call at the current floor opens the door on the first edge.
// Backpressure: none; call_req is a level sampled every cycle, and the position counter takes cnt_en/cnt_load unconditionally.
module floor_request_ctrl #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] call_req,
  output logic [1:0] cur_floor,
  output logic [3:0] pending,
  output logic       move_up,
  output logic       move_down,
  output logic       door_open,
  output logic       busy,
  output logic       cnt_en,
  output logic [3:0] cnt_load
);

  // One shared down-counter times both travel and dwell, so it is sized for the longer of the two.
  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] TRAVEL_RELOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_RELOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE     = TW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DOOR   = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          dir, dir_nxt;              // 1 = up, 0 = down
  logic [TW-1:0] timer, timer_nxt;
  logic [1:0]    floor_nxt;
  logic [3:0]    pending_nxt;
  logic [3:0]    req_eff;
  logic [3:0]    clr_mask;
  logic          cnt_en_nxt;
  logic [3:0]    cnt_load_nxt;
  logic [1:0]    new_floor;
  logic          ahead, behind;

  // Any call strictly above floor f.
  function automatic logic any_above(input logic [3:0] p, input logic [1:0] f);
    logic [3:0] m;
    m = 4'b1110 << f;
    return |(p & m);
  endfunction

  // Any call strictly below floor f.
  function automatic logic any_below(input logic [3:0] p, input logic [1:0] f);
    logic [3:0] m;
    m = ~(4'b1111 << f);
    return |(p & m);
  endfunction

  // Next-state, timer, floor and call-latch logic for the scheduler.
  always_comb begin
    state_nxt    = state;
    dir_nxt      = dir;
    timer_nxt    = timer;
    floor_nxt    = cur_floor;
    clr_mask     = 4'b0000;
    cnt_en_nxt   = 1'b0;
    cnt_load_nxt = cnt_load;
    new_floor    = cur_floor;
    ahead        = 1'b0;
    behind       = 1'b0;
    // Calls arriving this cycle count toward stops; moving off idle only
    // looks at latched calls so the move starts one cycle after the sample.
    req_eff      = pending | call_req;

    case (state)
      ST_IDLE: begin
        timer_nxt = '0;
        if (req_eff[cur_floor]) begin
          state_nxt           = ST_DOOR;
          timer_nxt           = DOOR_RELOAD;
          clr_mask[cur_floor] = 1'b1;
        end else if (any_above(pending, cur_floor) &&
                     (dir || !any_below(pending, cur_floor))) begin
          dir_nxt   = 1'b1;
          state_nxt = ST_MOVING;
          timer_nxt = TRAVEL_RELOAD;
        end else if (any_below(pending, cur_floor)) begin
          dir_nxt   = 1'b0;
          state_nxt = ST_MOVING;
          timer_nxt = TRAVEL_RELOAD;
        end
      end

      ST_MOVING: begin
        if (timer != '0) begin
          timer_nxt = timer - TIMER_ONE;
        end else begin
          // Saturating step: the floor number never wraps past 0 or 3.
          if (dir && (cur_floor != 2'd3)) begin
            new_floor = cur_floor + 2'd1;
          end else if (!dir && (cur_floor != 2'd0)) begin
            new_floor = cur_floor - 2'd1;
          end
          floor_nxt    = new_floor;
          cnt_en_nxt   = 1'b1;
          cnt_load_nxt = {2'b00, new_floor};
          ahead        = dir ? any_above(req_eff, new_floor) : any_below(req_eff, new_floor);
          behind       = dir ? any_below(req_eff, new_floor) : any_above(req_eff, new_floor);
          if (req_eff[new_floor]) begin
            state_nxt           = ST_DOOR;
            timer_nxt           = DOOR_RELOAD;
            clr_mask[new_floor] = 1'b1;
          end else if (ahead) begin
            timer_nxt = TRAVEL_RELOAD;
          end else if (behind) begin
            dir_nxt   = ~dir;
            timer_nxt = TRAVEL_RELOAD;
          end else begin
            state_nxt = ST_IDLE;
            timer_nxt = '0;
          end
        end
      end

      ST_DOOR: begin
        // A call at the open floor is absorbed by extending the dwell.
        clr_mask[cur_floor] = 1'b1;
        if (call_req[cur_floor]) begin
          timer_nxt = DOOR_RELOAD;
        end else if (timer != '0) begin
          timer_nxt = timer - TIMER_ONE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase

    // At the end floors only one direction makes sense.
    if (floor_nxt == 2'd3) begin
      dir_nxt = 1'b0;
    end else if (floor_nxt == 2'd0) begin
      dir_nxt = 1'b1;
    end

    // Serving a floor wins over a new call for that same floor.
    pending_nxt = req_eff & ~clr_mask;
  end

  // Scheduler state and registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      dir       <= 1'b1;
      timer     <= '0;
      cur_floor <= 2'd0;
      pending   <= 4'b0000;
      move_up   <= 1'b0;
      move_down <= 1'b0;
      door_open <= 1'b0;
      busy      <= 1'b0;
      cnt_en    <= 1'b0;
      cnt_load  <= 4'b0000;
    end else begin
      state     <= state_nxt;
      dir       <= dir_nxt;
      timer     <= timer_nxt;
      cur_floor <= floor_nxt;
      pending   <= pending_nxt;
      move_up   <= (state_nxt == ST_MOVING) &&  dir_nxt;
      move_down <= (state_nxt == ST_MOVING) && !dir_nxt;
      door_open <= (state_nxt == ST_DOOR);
      busy      <= (state_nxt != ST_IDLE);
      cnt_en    <= cnt_en_nxt;
      cnt_load  <= cnt_load_nxt;
    end
  end

endmodule

// File: tb/tb_floor_request_ctrl.sv
// Directed bench for the elevator call scheduler.
// Latency: outputs sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: none; the bench only drives call levels and reset.
module tb_floor_request_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] call_req;
  logic [1:0] cur_floor;
  logic [3:0] pending;
  logic       move_up;
  logic       move_down;
  logic       door_open;
  logic       busy;
  logic       cnt_en;
  logic [3:0] cnt_load;

  floor_request_ctrl #(
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .call_req (call_req),
    .cur_floor(cur_floor),
    .pending  (pending),
    .move_up  (move_up),
    .move_down(move_down),
    .door_open(door_open),
    .busy     (busy),
    .cnt_en   (cnt_en),
    .cnt_load (cnt_load)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Per-scenario observation counters.
  int          n_up, n_dn, n_en, n_bad, n_pend_door, n_cyc, door_run;
  int          first_move, first_door;
  logic [31:0] seq_word, door_word;
  logic [1:0]  prev_floor;
  logic        timed_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    call_req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic clear_stats();
    n_up        = 0;
    n_dn        = 0;
    n_en        = 0;
    n_bad       = 0;
    n_pend_door = 0;
    n_cyc       = 0;
    door_run    = 0;
    first_move  = 0;
    first_door  = 0;
    seq_word    = 32'h0;
    door_word   = 32'h0;
    prev_floor  = cur_floor;
    timed_out   = 1'b0;
  endtask

  // Fold one falling-edge observation into the scenario counters.
  task automatic sample();
    n_cyc++;
    if (move_up) n_up++;
    if (move_down) n_dn++;
    if ((move_up || move_down) && first_move == 0) first_move = n_cyc;
    if (door_open && first_door == 0) first_door = n_cyc;
    if (32'(move_up) + 32'(move_down) + 32'(door_open) > 32'd1) n_bad++;
    if (busy != (move_up | move_down | door_open)) n_bad++;
    if (cnt_en) begin
      n_en++;
      seq_word = (seq_word << 4) | 32'(cnt_load);
      if (cur_floor == prev_floor || cnt_load != {2'b00, cur_floor}) n_bad++;
    end else if (cur_floor != prev_floor) begin
      n_bad++;
    end
    prev_floor = cur_floor;
    if (door_open) begin
      door_run++;
      if (pending[cur_floor]) n_pend_door++;
    end else if (door_run > 0) begin
      door_word = (door_word << 8) | 32'(door_run);
      door_run  = 0;
    end
  endtask

  // Run until the car is idle with nothing pending; optionally inject one call
  // at a given cycle index or at a given cycle of a door dwell.
  task automatic track(input int inj_cyc, input logic [3:0] inj_req,
                       input int inj_door, input int max_cyc);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      sample();
      call_req = 4'b0000;
      if (n_cyc == inj_cyc || (inj_door > 0 && door_open && door_run == inj_door))
        call_req = inj_req;
      k++;
    end while ((busy || pending != 4'b0000) && k < max_cyc);
    timed_out = busy || (pending != 4'b0000);
  endtask

  initial begin
    rst      = 1'b0;
    call_req = 4'b0000;
    do_reset();

    // Reset state.
    check("rst_floor", 32'(cur_floor), 32'd0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_up", 32'(move_up), 32'd0);
    check("rst_down", 32'(move_down), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_cnt_load", 32'(cnt_load), 32'h0);

    // 1: call to floor 3 from idle at floor 0.
    clear_stats();
    call_req = 4'b1000;
    @(negedge clk);
    check("t1_latched", 32'(pending), 32'h8);
    check("t1_no_move_yet", 32'(move_up), 32'd0);
    sample();
    call_req = 4'b0000;
    track(0, 4'b0000, 0, 400);
    check("t1_done", 32'(timed_out), 32'd0);
    check("t1_first_move", 32'(first_move), 32'd2);
    check("t1_up_cycles", 32'(n_up), 32'd24);
    check("t1_down_cycles", 32'(n_dn), 32'd0);
    check("t1_door_runs", door_word, 32'h10);
    check("t1_load_seq", seq_word, 32'h123);
    check("t1_en_count", 32'(n_en), 32'd3);
    check("t1_floor", 32'(cur_floor), 32'd3);
    check("t1_pending", 32'(pending), 32'h0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_protocol", 32'(n_bad), 32'd0);

    // 2: call at the current floor opens the door immediately.
    do_reset();
    clear_stats();
    call_req = 4'b0001;
    track(0, 4'b0000, 0, 400);
    check("t2_done", 32'(timed_out), 32'd0);
    check("t2_first_door", 32'(first_door), 32'd1);
    check("t2_door_runs", door_word, 32'h10);
    check("t2_en_count", 32'(n_en), 32'd0);
    check("t2_moves", 32'(n_up + n_dn), 32'd0);
    check("t2_pending", 32'(pending), 32'h0);
    check("t2_protocol", 32'(n_bad), 32'd0);

    // 3: heading up to 3 with a call at 0 behind: serve 3 first, then 0.
    do_reset();
    clear_stats();
    call_req = 4'b1000;
    track(3, 4'b0001, 0, 400);
    check("t3_done", 32'(timed_out), 32'd0);
    check("t3_load_seq", seq_word, 32'h123210);
    check("t3_up_cycles", 32'(n_up), 32'd24);
    check("t3_down_cycles", 32'(n_dn), 32'd24);
    check("t3_door_runs", door_word, 32'h1010);
    check("t3_floor", 32'(cur_floor), 32'd0);
    check("t3_protocol", 32'(n_bad), 32'd0);

    // 4: call at 2 added while travelling 0->3 stops the car at 2 first.
    do_reset();
    clear_stats();
    call_req = 4'b1000;
    track(3, 4'b0100, 0, 400);
    check("t4_done", 32'(timed_out), 32'd0);
    check("t4_load_seq", seq_word, 32'h123);
    check("t4_door_runs", door_word, 32'h1010);
    check("t4_up_cycles", 32'(n_up), 32'd24);
    check("t4_floor", 32'(cur_floor), 32'd3);
    check("t4_protocol", 32'(n_bad), 32'd0);

    // 5: repeat call at the open floor on dwell cycle 10 extends it to 26.
    do_reset();
    clear_stats();
    call_req = 4'b0100;
    track(0, 4'b0100, 10, 400);
    check("t5_done", 32'(timed_out), 32'd0);
    check("t5_door_runs", door_word, 32'h1a);
    check("t5_load_seq", seq_word, 32'h12);
    check("t5_pend_in_dwell", 32'(n_pend_door), 32'd0);
    check("t5_floor", 32'(cur_floor), 32'd2);
    check("t5_protocol", 32'(n_bad), 32'd0);

    // 6: asynchronous reset in the middle of travel.
    do_reset();
    clear_stats();
    call_req = 4'b1000;
    repeat (12) begin
      @(negedge clk);
      sample();
      call_req = 4'b0000;
    end
    check("t6_pre_floor", 32'(cur_floor), 32'd1);
    check("t6_pre_up", 32'(move_up), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("t6_async_floor", 32'(cur_floor), 32'd0);
    check("t6_async_pending", 32'(pending), 32'h0);
    check("t6_async_outs",
          32'({move_up, move_down, door_open, busy, cnt_en, cnt_load}), 32'h0);
    @(negedge clk);
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_post_busy", 32'(busy), 32'd0);
    check("t6_post_floor", 32'(cur_floor), 32'd0);
    check("t6_post_pending", 32'(pending), 32'h0);
    check("t6_post_move", 32'({move_up, move_down}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
